// File: rtl/banco_registradores_param_if.sv
// Bus between the datapath control unit and the register file: write port,
// two read ports and the sequential-clear handshake.
interface banco_registradores_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              enable;
   logic [ADDR_W-1:0] endereco_escrita;
   logic [DATA_W-1:0] conteudo_escrita;
   logic [ADDR_W-1:0] endereco_reg1;
   logic [ADDR_W-1:0] endereco_reg2;
   logic [DATA_W-1:0] conteudo_reg1;
   logic [DATA_W-1:0] conteudo_reg2;
   logic              ativar_clear;
   logic              ocupado;
   logic              clear_pronto;
   logic              escrita_descartada;

   modport master (
      output enable, endereco_escrita, conteudo_escrita,
      output endereco_reg1, endereco_reg2, ativar_clear,
      input  conteudo_reg1, conteudo_reg2, ocupado, clear_pronto, escrita_descartada
   );

   modport slave (
      input  enable, endereco_escrita, conteudo_escrita,
      input  endereco_reg1, endereco_reg2, ativar_clear,
      output conteudo_reg1, conteudo_reg2, ocupado, clear_pronto, escrita_descartada
   );
endinterface

// File: rtl/banco_registradores_param.sv
// Parametrised DEPTH x DATA_W register file: two combinational read ports, one
// synchronous write port, optional bypass / hardwired-zero entry 0, sequential clear engine.
module banco_registradores_param #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter bit BYPASS    = 1'b1,
   parameter bit ZERO_REG0 = 1'b0
) (
   input logic                   clk,
   input logic                   rst_n,
   banco_registradores_param_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      LIMPANDO = 2'd1,
      FIM      = 2'd2
   } estado_t;

   estado_t           estado, estado_prox;
   logic [ADDR_W-1:0] ptr, ptr_prox;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              ocupado;
   logic              escrita_aceita;
   logic              escrita_efetiva;

   // Bypass is resolved first so that the hardwired-zero entry always wins.
   function automatic logic [DATA_W-1:0] ler_porta(
      input logic [ADDR_W-1:0] endereco,
      input logic [DATA_W-1:0] armazenado,
      input logic              aceita,
      input logic [ADDR_W-1:0] end_escrita,
      input logic [DATA_W-1:0] dado_escrita
   );
      logic [DATA_W-1:0] r;
      r = armazenado;
      if (BYPASS && aceita && (endereco == end_escrita))
         r = dado_escrita;
      if (ZERO_REG0 && (endereco == '0))
         r = '0;
      return r;
   endfunction

   assign ocupado         = (estado == LIMPANDO);
   assign escrita_aceita  = bus.enable && !ocupado;
   assign escrita_efetiva = escrita_aceita && !(ZERO_REG0 && (bus.endereco_escrita == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= OCIOSO;
         ptr    <= '0;
      end else begin
         estado <= estado_prox;
         ptr    <= ptr_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      ptr_prox    = ptr;
      case (estado)
         OCIOSO: begin
            if (bus.ativar_clear) begin
               estado_prox = LIMPANDO;
               ptr_prox    = '0;
            end
         end
         LIMPANDO: begin
            // The pointer wraps to zero on the same edge the engine leaves for FIM.
            ptr_prox = ptr + 1'b1;
            if (ptr == {ADDR_W{1'b1}})
               estado_prox = FIM;
         end
         FIM: begin
            if (bus.ativar_clear) begin
               estado_prox = LIMPANDO;
               ptr_prox    = '0;
            end else begin
               estado_prox = OCIOSO;
            end
         end
         default: begin
            estado_prox = OCIOSO;
            ptr_prox    = '0;
         end
      endcase
   end

   // Writes are blocked while clearing, so the clear and write paths never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (ocupado) begin
         mem[ptr] <= '0;
      end else if (escrita_efetiva) begin
         mem[bus.endereco_escrita] <= bus.conteudo_escrita;
      end
   end

   assign bus.conteudo_reg1 = ler_porta(bus.endereco_reg1, mem[bus.endereco_reg1],
                                        escrita_aceita, bus.endereco_escrita, bus.conteudo_escrita);
   assign bus.conteudo_reg2 = ler_porta(bus.endereco_reg2, mem[bus.endereco_reg2],
                                        escrita_aceita, bus.endereco_escrita, bus.conteudo_escrita);

   assign bus.ocupado            = ocupado;
   assign bus.clear_pronto       = (estado == FIM);
   assign bus.escrita_descartada = bus.enable && ocupado;

endmodule
